// File: rtl/product_combiner_8.sv
// rtl/product_combiner_8.sv - recombines eight 8x8 partial products into SEW 8/16/32 results
module product_combiner_8 (
   input  logic        clk,
   input  logic        reset,
   input  logic        prod_valid,
   output logic        prod_ready,
   input  logic [1:0]  sew,
   input  logic        phase,
   input  logic [15:0] mult1_P,
   input  logic [15:0] mult2_P,
   input  logic [15:0] mult3_P,
   input  logic [15:0] mult4_P,
   input  logic [15:0] mult5_P,
   input  logic [15:0] mult6_P,
   input  logic [15:0] mult7_P,
   input  logic [15:0] mult8_P,
   output logic [63:0] result,
   output logic [1:0]  result_sew,
   output logic        result_valid,
   input  logic        result_ready,
   output logic        err
);

   typedef enum logic {IDLE, HALF} state_t;

   state_t      state, state_next;
   logic [47:0] acc, acc_next;
   logic [47:0] pass_sum;
   logic [31:0] sum16_lo, sum16_hi;
   logic [63:0] sum32;
   logic        accept;
   logic        load;
   logic [63:0] load_data;
   logic [1:0]  load_sew;
   logic        err_next;

   // The output register can take a new beat whenever it is empty or being drained
   assign prod_ready = !result_valid || result_ready;
   assign accept     = prod_valid && prod_ready;

   // Arithmetic shared by all element widths; a 32-bit pass sum never exceeds 48 bits
   always_comb begin
      pass_sum = 48'(mult1_P)
               + (48'(mult2_P) << 8)
               + (48'(mult3_P) << 16)
               + (48'(mult4_P) << 24)
               + (48'(mult5_P) << 8)
               + (48'(mult6_P) << 16)
               + (48'(mult7_P) << 24)
               + (48'(mult8_P) << 32);
      sum16_lo = 32'(mult1_P) + (32'(mult2_P) << 8) + (32'(mult5_P) << 8) + (32'(mult6_P) << 16);
      sum16_hi = 32'(mult3_P) + (32'(mult4_P) << 8) + (32'(mult7_P) << 8) + (32'(mult8_P) << 16);
      sum32    = 64'(acc) + (64'(pass_sum) << 16);
   end

   // Next-state, accumulator update, result load and protocol-error decode
   always_comb begin
      state_next = state;
      acc_next   = acc;
      load       = 1'b0;
      load_data  = 64'd0;
      load_sew   = sew;
      err_next   = 1'b0;
      if (accept) begin
         if (state == HALF && sew == 2'b10 && phase) begin
            load       = 1'b1;
            load_data  = sum32;
            acc_next   = 48'd0;
            state_next = IDLE;
         end else begin
            // A pending low pass is abandoned by anything but its high pass
            err_next   = (state == HALF);
            acc_next   = 48'd0;
            state_next = IDLE;
            if (phase || sew == 2'b11) begin
               err_next = 1'b1;
            end else begin
               case (sew)
                  2'b00: begin
                     load      = 1'b1;
                     load_data = {mult4_P, mult3_P, mult2_P, mult1_P};
                  end
                  2'b01: begin
                     load      = 1'b1;
                     load_data = {sum16_hi, sum16_lo};
                  end
                  default: begin
                     acc_next   = pass_sum;
                     state_next = HALF;
                  end
               endcase
            end
         end
      end
   end

   // State, accumulator and registered error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         acc   <= 48'd0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         err   <= err_next;
      end
   end

   // Output holding register; a load in the consume cycle replaces without a bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         result       <= 64'd0;
         result_sew   <= 2'b00;
         result_valid <= 1'b0;
      end else if (load) begin
         result       <= load_data;
         result_sew   <= load_sew;
         result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
         result_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_product_combiner_8.sv
// tb/tb_product_combiner_8.sv - directed self-checking bench for product_combiner_8
module tb_product_combiner_8;

   logic        clk = 1'b0;
   logic        reset;
   logic        prod_valid;
   logic        prod_ready;
   logic [1:0]  sew;
   logic        phase;
   logic [15:0] p [8];
   logic [63:0] result;
   logic [1:0]  result_sew;
   logic        result_valid;
   logic        result_ready;
   logic        err;

   int checks = 0;
   int passed = 0;

   product_combiner_8 dut (
      .clk          (clk),
      .reset        (reset),
      .prod_valid   (prod_valid),
      .prod_ready   (prod_ready),
      .sew          (sew),
      .phase        (phase),
      .mult1_P      (p[0]),
      .mult2_P      (p[1]),
      .mult3_P      (p[2]),
      .mult4_P      (p[3]),
      .mult5_P      (p[4]),
      .mult6_P      (p[5]),
      .mult7_P      (p[6]),
      .mult8_P      (p[7]),
      .result       (result),
      .result_sew   (result_sew),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .err          (err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] s, input logic ph,
                       input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3, input logic [15:0] a4,
                       input logic [15:0] a5, input logic [15:0] a6, input logic [15:0] a7, input logic [15:0] a8);
      prod_valid = 1'b1;
      sew   = s;
      phase = ph;
      p[0] = a1; p[1] = a2; p[2] = a3; p[3] = a4;
      p[4] = a5; p[5] = a6; p[6] = a7; p[7] = a8;
   endtask

   task automatic idle();
      prod_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_result"}, result, 64'd0);
      check({tag, "_sew"}, 64'(result_sew), 64'd0);
      check({tag, "_valid"}, 64'(result_valid), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      prod_valid = 1'b0;
      result_ready = 1'b1;
      beat(2'b00, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      prod_valid = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      check("reset_prod_ready", 64'(prod_ready), 64'd1);
      reset = 1'b0;

      // SEW 8: mult5..8 must be ignored
      beat(2'b00, 1'b0, 16'h0005, 16'h000C, 16'h0015, 16'h0020, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h1234);
      tick();
      idle();
      check("sew8_result", result, 64'h0020_0015_000C_0005);
      check("sew8_sew", 64'(result_sew), 64'd0);
      check("sew8_valid", 64'(result_valid), 64'd1);
      check("sew8_err", 64'(err), 64'd0);
      tick();
      check("sew8_drained", 64'(result_valid), 64'd0);

      // SEW 16 back-to-back: 0x1234*0x5678 in the low lane, then a high-lane vector
      beat(2'b01, 1'b0, 16'h1860, 16'h0870, 16'h0000, 16'h0000, 16'h1178, 16'h060C, 16'h0000, 16'h0000);
      tick();
      check("sew16_result", result, 64'h0000_0000_0626_0060);
      check("sew16_sew", 64'(result_sew), 64'd1);
      check("sew16_prod_ready", 64'(prod_ready), 64'd1);
      beat(2'b01, 1'b0, 16'h0000, 16'h0000, 16'h0102, 16'h0304, 16'h0000, 16'h0000, 16'h0506, 16'h0708);
      tick();
      idle();
      check("sew16_hi_result", result, 64'h0710_0B02_0000_0000);
      check("sew16_hi_valid", 64'(result_valid), 64'd1);
      tick();

      // SEW 32: 0xFFFFFFFF squared over two non-consecutive passes
      beat(2'b10, 1'b0, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01);
      tick();
      idle();
      check("sew32_p0_valid", 64'(result_valid), 64'd0);
      check("sew32_p0_err", 64'(err), 64'd0);
      tick();
      tick();
      check("sew32_wait_valid", 64'(result_valid), 64'd0);
      beat(2'b10, 1'b1, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01);
      tick();
      idle();
      check("sew32_result", result, 64'hFFFF_FFFE_0000_0001);
      check("sew32_sew", 64'(result_sew), 64'd2);
      check("sew32_valid", 64'(result_valid), 64'd1);
      check("sew32_err", 64'(err), 64'd0);
      tick();

      // Backpressure: held result stays stable and the waiting beat is not lost
      result_ready = 1'b0;
      beat(2'b00, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0, 0, 0);
      tick();
      beat(2'b00, 1'b0, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 0, 0, 0, 0);
      check("bp_prod_ready_low", 64'(prod_ready), 64'd0);
      tick();
      tick();
      tick();
      check("bp_result_stable", result, 64'h4444_3333_2222_1111);
      check("bp_valid_held", 64'(result_valid), 64'd1);
      check("bp_prod_ready_still_low", 64'(prod_ready), 64'd0);
      result_ready = 1'b1;
      #1;
      check("bp_prod_ready_rise", 64'(prod_ready), 64'd1);
      tick();
      idle();
      check("bp_next_result", result, 64'h8888_7777_6666_5555);
      check("bp_next_valid", 64'(result_valid), 64'd1);
      tick();
      check("bp_drained", 64'(result_valid), 64'd0);

      // Phase-1 beat in IDLE
      beat(2'b10, 1'b1, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      check("ph1_idle_err", 64'(err), 64'd1);
      check("ph1_idle_valid", 64'(result_valid), 64'd0);
      tick();
      check("ph1_idle_err_clear", 64'(err), 64'd0);

      // SEW 32 low pass interrupted by a SEW 8 beat
      beat(2'b10, 1'b0, 16'h0101, 16'h0202, 0, 0, 0, 0, 0, 0);
      tick();
      beat(2'b00, 1'b0, 16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 16'h9999, 0, 0, 0);
      tick();
      idle();
      check("interrupt_err", 64'(err), 64'd1);
      check("interrupt_result", result, 64'h00DD_00CC_00BB_00AA);
      check("interrupt_valid", 64'(result_valid), 64'd1);
      check("interrupt_sew", 64'(result_sew), 64'd0);
      tick();
      check("interrupt_err_clear", 64'(err), 64'd0);
      // The abandoned accumulator must not pair with a later phase-1 beat
      beat(2'b10, 1'b1, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      check("after_interrupt_ph1_err", 64'(err), 64'd1);
      check("after_interrupt_ph1_valid", 64'(result_valid), 64'd0);
      tick();

      // Illegal sew
      beat(2'b11, 1'b0, 16'h0001, 16'h0002, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      check("sew11_err", 64'(err), 64'd1);
      check("sew11_valid", 64'(result_valid), 64'd0);
      tick();

      // Reset in HALF abandons the low pass
      beat(2'b10, 1'b0, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01);
      tick();
      idle();
      reset = 1'b1;
      tick();
      check_reset_outputs("midreset");
      reset = 1'b0;
      beat(2'b10, 1'b1, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01);
      tick();
      idle();
      check("postreset_ph1_err", 64'(err), 64'd1);
      check("postreset_ph1_valid", 64'(result_valid), 64'd0);
      tick();

      // Reset discards a held result
      result_ready = 1'b0;
      beat(2'b00, 1'b0, 16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C, 0, 0, 0, 0);
      tick();
      idle();
      check("held_before_reset", 64'(result_valid), 64'd1);
      reset = 1'b1;
      tick();
      check_reset_outputs("heldreset");
      reset = 1'b0;
      result_ready = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/product_combiner_8.md
# product_combiner_8

Recombines the eight 16-bit partial products from the 8×8 multiplier array into final double-width results for SEW = 8, 16 or 32. It sits downstream of the operand distributor and multiplier array in the vector execution unit. It accumulates the two passes that a 32-bit multiply needs and presents one 64-bit result word through a valid/ready output register.

## Interface
Parameters:
- none; widths are fixed by the 8-multiplier array.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset; synchronous, active-high.
- prod_valid  in  1  the products, sew and phase inputs are valid this cycle.
- prod_ready  out  1  beat accepted when prod_valid && prod_ready.
- sew  in  2  element width: 00 = 8 bit, 01 = 16 bit, 10 = 32 bit, 11 = illegal.
- phase  in  1  32-bit pass select: 0 = B[15:0] pass, 1 = B[31:16] pass. Must be 0 for SEW 8/16.
- mult1_P … mult8_P  in  16 each  unsigned products of multipliers 1–8.
- result  out  64  packed unsigned result.
- result_sew  out  2  sew of the held result.
- result_valid  out  1  result is held and valid.
- result_ready  in  1  consumer accepts the result when result_valid && result_ready.
- err  out  1  one-cycle pulse on a protocol violation.

## Operation
- Notation: p1..p8 = mult1_P..mult8_P.
- Pass sum S = Σ(i=0..3) p(i+1)<<8i + Σ(i=0..3) p(i+5)<<(8i+8). S is 48 bits and never overflows.
- State machine: IDLE (no pending pass) and HALF (32-bit low pass held in the 48-bit register acc).
- Accepted beats in IDLE:
  - SEW 8, phase 0: result = {p4,p3,p2,p1}; element i occupies bits [16i+15:16i]. Mult5–8 are ignored.
  - SEW 16, phase 0:
    - result[31:0] = p1 + (p2<<8) + (p5<<8) + (p6<<16).
    - result[63:32] = p3 + (p4<<8) + (p7<<8) + (p8<<16).
  - SEW 32, phase 0: acc ← S; go to HALF; no result.
  - phase 1, or sew = 11: beat dropped, err pulses, stay IDLE.
- Accepted beats in HALF:
  - SEW 32, phase 1: result = acc + (S<<16), truncated to 64 bits; acc ← 0; go to IDLE.
  - Any other beat: acc discarded, err pulses, and the beat is then processed exactly as in IDLE. This covers a SEW 32 phase 0 beat, which restarts HALF.
- Loading a result sets result_valid and captures result_sew.
- Output register:
  - The held result stays stable until consumed.
  - result_valid clears on consumption unless a new result loads in the same cycle.
- prod_ready = !result_valid || result_ready, combinational, in both states.
- All arithmetic is unsigned.

## Timing
- Reset values: result = 0, result_sew = 00, result_valid = 0, err = 0, acc = 0, state = IDLE.
- Latency:
  - SEW 8/16: result_valid is high in the cycle after the beat is accepted.
  - SEW 32: result_valid is high in the cycle after the phase-1 beat. The phase-0 and phase-1 beats need not be consecutive; HALF waits indefinitely.
- Throughput: one result per cycle for SEW 8/16 when result_ready is held high.
- Simultaneous consume and accept: the new result replaces the old one with no bubble.
- err is registered and high for exactly the cycle after the offending beat.
- Reset mid-operation: HALF is abandoned, acc is cleared, and any held result is lost. A phase-1 beat after reset produces err.
- An unaccepted beat (prod_ready low) causes no state change and no err.

## Test plan
- SEW 8: p1..p4 = 0x0005, 0x000C, 0x0015, 0x0020 (p5..p8 arbitrary) → next cycle result = 0x0020_0015_000C_0005, result_sew = 00.
- SEW 16:
  - Stimulus: p1 = 0x34·0x78, p2 = 0x12·0x78, p5 = 0x34·0x56, p6 = 0x12·0x56; p3, p4, p7, p8 = 0.
  - Required: result = 0x0000_0000_0626_0060 (0x1234 × 0x5678).
- SEW 32: A = B = 0xFFFFFFFF, all products 0xFE01, two beats (phase 0, then phase 1 three cycles later) → no result_valid after the first beat; result = 0xFFFF_FFFE_0000_0001 after the second.
- Backpressure: result_ready held low for 3 cycles with prod_valid high → result stable, prod_ready low, no beat lost. The next beat is accepted in the cycle result_ready rises.
- Protocol errors:
  - phase-1 beat in IDLE → err pulse, no result.
  - SEW 32 phase 0, then a SEW 8 beat → err pulse and the correct SEW 8 result.
  - sew = 11 → err pulse, no result.
- Reset: SEW 32 phase-0 beat, reset for 1 cycle, then a phase-1 beat → err pulse, result_valid stays 0, and all outputs are at reset values during reset.
